// File: rtl/game_pkg.sv
// Shared types and constants for the whack-a-mole game logic.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    ACTIVE,
    COOLDOWN,
    GAME_OVER
  } state_e;

  // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0]
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
  localparam int         CNT_W        = 8;
  localparam int         SPEEDUP_HITS = 5;

  // Counter increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/mole_controller_if.sv
// Game-side bus: divider level and player inputs in, display/LED data out.
interface mole_controller_if #(
  parameter int NUM_HOLES = 9
);
  import game_pkg::*;

  logic                 slow_clk;
  logic                 start;
  logic [NUM_HOLES-1:0] btn;
  logic [NUM_HOLES-1:0] mole;
  logic [CNT_W-1:0]     score;
  logic [CNT_W-1:0]     misses;
  logic [CNT_W-1:0]     time_left;
  logic                 game_over;

  modport master (
    output slow_clk, start, btn,
    input  mole, score, misses, time_left, game_over
  );

  modport slave (
    input  slow_clk, start, btn,
    output mole, score, misses, time_left, game_over
  );

endinterface

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR used as the hole-selection random source.
module lfsr8
  import game_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  output logic [7:0] state_o
);

  logic [7:0] lfsr_q, lfsr_d;

  // Shift left, feedback is the parity of the tapped bits
  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // State register, seeded on reset
  always_ff @(posedge clk) begin
    if (!reset) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/mole_controller.sv
// Whack-a-mole game FSM: tick extraction from the divider level, mole
// spawning at LFSR-chosen holes, hit/miss scoring and the game countdown.
// Optional HIT_SPEEDUP_EN: mole lifetime shrinks by one tick after every
// fifth hit (floor of one tick), restored on start.
module mole_controller
  import game_pkg::*;
#(
  parameter int         NUM_HOLES  = 9,
  parameter int         MOLE_TICKS = 3,
  parameter int         GAME_TICKS = 80,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  mole_controller_if.slave  bus
);

  localparam int         IDX_W = $clog2(NUM_HOLES);
  localparam logic [3:0] MT    = 4'(MOLE_TICKS);

  state_e               state_q, state_d;
  logic                 slow_q;
  logic                 tick;
  logic                 in_play;
  logic [7:0]           lfsr;
  logic [7:0]           raw_idx;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     prev_idx_q, prev_idx_d;
  logic [3:0]           mole_cnt_q, mole_cnt_d;
  logic [NUM_HOLES-1:0] mole_q, mole_d;
  logic [CNT_W-1:0]     score_q, score_d;
  logic [CNT_W-1:0]     misses_q, misses_d;
  logic [CNT_W-1:0]     time_q, time_d;
  logic [3:0]           reload;
`ifdef HIT_SPEEDUP_EN
  logic [3:0]           reload_q, reload_d;
  assign reload = reload_q;
`else
  assign reload = MT;
`endif

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .en_i    (1'b1),
    .state_o (lfsr)
  );

  // Either edge of the divider level is one game tick
  assign tick    = bus.slow_clk ^ slow_q;
  assign in_play = (state_q == SPAWN) || (state_q == ACTIVE) || (state_q == COOLDOWN);

  // Hole pick; never repeat the previous hole back-to-back
  always_comb begin
    raw_idx = lfsr % 8'(NUM_HOLES);
    idx     = IDX_W'((raw_idx == 8'(prev_idx_q)) ? ((raw_idx + 8'd1) % 8'(NUM_HOLES))
                                                  : raw_idx);
  end

  // Next-state and datapath updates; game end overrides the phase decision
  always_comb begin
    state_d    = state_q;
    mole_d     = mole_q;
    prev_idx_d = prev_idx_q;
    mole_cnt_d = mole_cnt_q;
    score_d    = score_q;
    misses_d   = misses_q;
    time_d     = time_q;
`ifdef HIT_SPEEDUP_EN
    reload_d   = reload_q;
`endif
    unique case (state_q)
      IDLE, GAME_OVER: begin
        mole_d = '0;
        if (bus.start) begin
          score_d  = '0;
          misses_d = '0;
          time_d   = CNT_W'(GAME_TICKS);
          state_d  = SPAWN;
`ifdef HIT_SPEEDUP_EN
          reload_d = MT;
`endif
        end
      end
      SPAWN: begin
        mole_d      = '0;
        mole_d[idx] = 1'b1;
        prev_idx_d  = idx;
        mole_cnt_d  = reload;
        state_d     = ACTIVE;
      end
      ACTIVE: begin
        if ((bus.btn & mole_q) != '0) begin
          score_d = sat_inc(score_q);
          mole_d  = '0;
          state_d = COOLDOWN;
`ifdef HIT_SPEEDUP_EN
          if ((score_d % CNT_W'(SPEEDUP_HITS)) == '0 && reload_q > 4'd1)
            reload_d = reload_q - 4'd1;
`endif
        end else if (bus.btn != '0) begin
          misses_d = sat_inc(misses_q);
        end else if (tick) begin
          mole_cnt_d = mole_cnt_q - 4'd1;
          if (mole_cnt_q == 4'd1) begin
            misses_d = sat_inc(misses_q);
            mole_d   = '0;
            state_d  = COOLDOWN;
          end
        end
      end
      COOLDOWN: begin
        mole_d = '0;
        if (tick) state_d = SPAWN;
      end
      default: state_d = IDLE;
    endcase

    if (in_play && tick) begin
      time_d = time_q - CNT_W'(1);
      if (time_q == CNT_W'(1)) begin
        state_d = GAME_OVER;
        mole_d  = '0;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      slow_q     <= 1'b0;
      prev_idx_q <= '0;
      mole_cnt_q <= '0;
      mole_q     <= '0;
      score_q    <= '0;
      misses_q   <= '0;
      time_q     <= '0;
`ifdef HIT_SPEEDUP_EN
      reload_q   <= MT;
`endif
    end else begin
      state_q    <= state_d;
      slow_q     <= bus.slow_clk;
      prev_idx_q <= prev_idx_d;
      mole_cnt_q <= mole_cnt_d;
      mole_q     <= mole_d;
      score_q    <= score_d;
      misses_q   <= misses_d;
      time_q     <= time_d;
`ifdef HIT_SPEEDUP_EN
      reload_q   <= reload_d;
`endif
    end
  end

  assign bus.mole      = mole_q;
  assign bus.score     = score_q;
  assign bus.misses    = misses_q;
  assign bus.time_left = time_q;
  assign bus.game_over = (state_q == GAME_OVER);

endmodule

// File: tb/tb_mole_controller.sv
// Directed bench for mole_controller: a default-length game (u_dut) and a
// four-tick game (u_dut4) for the end-of-game corner cases.
module tb_mole_controller;

  localparam int NH = 9;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mole_controller_if #(.NUM_HOLES(NH)) ifa ();
  mole_controller_if #(.NUM_HOLES(NH)) ifb ();

  mole_controller #(.NUM_HOLES(NH), .MOLE_TICKS(3), .GAME_TICKS(80), .LFSR_SEED(8'hA5)) u_dut (
    .clk(clk), .reset(reset), .bus(ifa.slave));

  mole_controller #(.NUM_HOLES(NH), .MOLE_TICKS(3), .GAME_TICKS(4), .LFSR_SEED(8'hA5)) u_dut4 (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  int n_chk = 0;
  int n_pass = 0;
  int prev_m = 0;
  logic [7:0] lfsr_m;

  // Reference LFSR: taps 8,6,5,4, seeded by reset, advances every cycle
  always @(posedge clk) begin
    if (!reset) lfsr_m <= 8'hA5;
    else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_a();
    ifa.slow_clk = ~ifa.slow_clk;
    step();
  endtask

  task automatic tick_b();
    ifb.slow_clk = ~ifb.slow_clk;
    step();
  endtask

  function automatic int nxt_idx(input logic [7:0] l, input int p);
    int i;
    i = int'(l) % NH;
    if (i == p) i = (i + 1) % NH;
    return i;
  endfunction

  // Call during u_dut's SPAWN cycle; checks the mole that appears next
  task automatic spawn_a(input string tag, output int idx);
    idx = nxt_idx(lfsr_m, prev_m);
    prev_m = idx;
    step();
    chk(tag, 32'(ifa.mole), 32'(1) << idx);
  endtask

  initial begin
    int i1, i2, i3, i4, w, exp_to;
    ifa.slow_clk = 1'b0; ifa.start = 1'b0; ifa.btn = '0;
    ifb.slow_clk = 1'b0; ifb.start = 1'b0; ifb.btn = '0;

    // Reset with the divider running
    repeat (4) begin ifb.slow_clk = ~ifb.slow_clk; tick_a(); end
    chk("rst_mole",   32'(ifa.mole), 0);
    chk("rst_score",  32'(ifa.score), 0);
    chk("rst_misses", 32'(ifa.misses), 0);
    chk("rst_time",   32'(ifa.time_left), 0);
    chk("rst_go",     32'(ifa.game_over), 0);
    reset = 1'b1;
    repeat (3) tick_a();
    chk("idle_no_mole", 32'(ifa.mole), 0);
    chk("idle_time",    32'(ifa.time_left), 0);

    // Start and hit the first mole
    ifa.start = 1'b1; step(); ifa.start = 1'b0;
    chk("start_time", 32'(ifa.time_left), 80);
    spawn_a("spawn1", i1);
    ifa.btn[i1] = 1'b1; step(); ifa.btn = '0;
    chk("hit_score", 32'(ifa.score), 1);
    chk("hit_clear", 32'(ifa.mole), 0);
    tick_a();
    spawn_a("spawn2", i2);
    chk("new_hole", 32'(ifa.mole[i1]), 0);
    chk("time_79",  32'(ifa.time_left), 79);

    // Timeout miss on the third tick, respawn on the next
    tick_a();
    chk("tmo_t1_up", 32'(ifa.mole), 32'(1) << i2);
    tick_a();
    chk("tmo_t2_up", 32'(ifa.mole), 32'(1) << i2);
    tick_a();
    chk("tmo_miss",  32'(ifa.misses), 1);
    chk("tmo_clear", 32'(ifa.mole), 0);
    tick_a();
    spawn_a("spawn3", i3);

    // Wrong press, then wrong+right together
    w = (i3 + 4) % NH;
    ifa.btn[w] = 1'b1; step(); ifa.btn = '0;
    chk("wrong_miss", 32'(ifa.misses), 2);
    chk("wrong_stay", 32'(ifa.mole), 32'(1) << i3);
    ifa.btn[w] = 1'b1; ifa.btn[i3] = 1'b1; step(); ifa.btn = '0;
    chk("multi_score",  32'(ifa.score), 2);
    chk("multi_misses", 32'(ifa.misses), 2);
    chk("multi_clear",  32'(ifa.mole), 0);

    // Miss counter saturation via held wrong press
    tick_a();
    spawn_a("spawn4", i4);
    ifa.btn[(i4 + 1) % NH] = 1'b1;
    repeat (260) step();
    ifa.btn = '0;
    chk("misses_sat", 32'(ifa.misses), 255);
    chk("sat_mole",   32'(ifa.mole), 32'(1) << i4);
    chk("time_74",    32'(ifa.time_left), 74);

    // Reset in the middle of a game
    reset = 1'b0; step(); reset = 1'b1; prev_m = 0;
    chk("mid_rst_mole",  32'(ifa.mole), 0);
    chk("mid_rst_score", 32'(ifa.score), 0);
    chk("mid_rst_miss",  32'(ifa.misses), 0);
    chk("mid_rst_time",  32'(ifa.time_left), 0);

    // Five hits, then measure the mole lifetime
    ifa.start = 1'b1; step(); ifa.start = 1'b0;
    spawn_a("sp_first", i1);
    for (int k = 0; k < 5; k++) begin
      ifa.btn[i1] = 1'b1; step(); ifa.btn = '0;
      tick_a();
      spawn_a("sp_respawn", i1);
    end
    chk("five_hits", 32'(ifa.score), 5);
`ifdef HIT_SPEEDUP_EN
    exp_to = 2;
`else
    exp_to = 3;
`endif
    repeat (exp_to - 1) tick_a();
    chk("lifetime_up",   32'(ifa.mole), 32'(1) << i1);
    tick_a();
    chk("lifetime_miss", 32'(ifa.misses), 1);
    chk("lifetime_clr",  32'(ifa.mole), 0);

    // Short game: hit lands on the final tick
    ifb.start = 1'b1; step(); ifb.start = 1'b0;
    chk("g4_time", 32'(ifb.time_left), 4);
    step();
    chk("g4_mole_up", 32'(ifb.mole != '0), 1);
    tick_b();
    ifb.btn = ifb.mole; step(); ifb.btn = '0;
    chk("g4_hit1", 32'(ifb.score), 1);
    tick_b();
    step();
    tick_b();
    chk("g4_time1", 32'(ifb.time_left), 1);
    ifb.btn = ifb.mole; ifb.slow_clk = ~ifb.slow_clk; step(); ifb.btn = '0;
    chk("g4_end_score", 32'(ifb.score), 2);
    chk("g4_end_go",    32'(ifb.game_over), 1);
    chk("g4_end_mole",  32'(ifb.mole), 0);
    chk("g4_end_time",  32'(ifb.time_left), 0);
    repeat (3) tick_b();
    chk("g4_hold_score", 32'(ifb.score), 2);
    chk("g4_hold_time",  32'(ifb.time_left), 0);
    chk("g4_hold_go",    32'(ifb.game_over), 1);
    ifb.start = 1'b1; step(); ifb.start = 1'b0;
    chk("g4_restart_score", 32'(ifb.score), 0);
    chk("g4_restart_time",  32'(ifb.time_left), 4);
    chk("g4_restart_go",    32'(ifb.game_over), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mole_controller.md
Name: mole_controller

Overview:
- Game-logic stage directly downstream of the clock divider in the whack-a-mole design.
- Consumes the divider's slow_clk level, which is registered in the same clk domain. Each toggle of slow_clk becomes a one-cycle game tick, i.e. every 0.75 s at 100 MHz.
- Spawns one mole at a time at a pseudo-random hole, scores hits from debounced button pulses, counts misses and runs the game countdown.
- Outputs drive the LED and 7-segment display stages.

Parameters:
- NUM_HOLES, 9, number of holes/buttons (2..16).
- MOLE_TICKS, 3, ticks a mole stays up before it counts as a miss (1..15).
- GAME_TICKS, 80, game length in ticks (1..255).
- LFSR_SEED, 8'hA5, LFSR reset value (must be non-zero).

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-low reset.
- slow_clk  in  1  divider output; level, synchronous to clk.
- start  in  1  one-cycle pulse that starts a new game.
- btn  in  NUM_HOLES  debounced one-cycle press pulses, one bit per hole.
- mole  out  NUM_HOLES  one-hot active mole; all zero when no mole is up.
- score  out  8  hits, saturating at 255.
- misses  out  8  misses, saturating at 255.
- time_left  out  8  remaining ticks.
- game_over  out  1  high in GAME_OVER state.

Behaviour:
- Reset (reset==0 at posedge clk):
  - mole=0, score=0, misses=0, time_left=0, game_over=0.
  - state=IDLE, slow_q=0, lfsr=LFSR_SEED, prev_idx=0, mole_cnt=0.
  - Reset overrides every other input in that cycle, including reset mid-game.
- Tick: slow_q<=slow_clk every cycle; tick = slow_clk ^ slow_q, so both edges produce a tick.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, advances every clk cycle in every state.
- Hole selection: idx = lfsr % NUM_HOLES. If idx==prev_idx, use (idx+1)%NUM_HOLES instead.
- States:
  - IDLE: mole=0. start -> SPAWN; score=0, misses=0, time_left=GAME_TICKS, game_over=0.
  - SPAWN (exactly 1 cycle): mole<=1<<idx, prev_idx<=idx, mole_cnt<=MOLE_TICKS -> ACTIVE. The mole is visible on the cycle after SPAWN.
  - ACTIVE, evaluated in priority order:
    - Hit: (btn & mole)!=0 -> score+1, mole<=0 -> COOLDOWN.
    - Wrong press: btn!=0 with no match -> misses+1, stay in ACTIVE.
    - tick: mole_cnt-1. If mole_cnt was 1, misses+1, mole<=0 -> COOLDOWN.
  - COOLDOWN: mole=0. Next tick -> SPAWN. Button presses are ignored.
  - GAME_OVER: mole=0, game_over=1, score/misses held. start -> same actions as from IDLE.
- Countdown: in SPAWN, ACTIVE and COOLDOWN, each tick decrements time_left. On the tick that brings time_left 1->0, go to GAME_OVER with mole<=0.
- Countdown priority vs hit: if a hit and the final tick land in the same cycle, the hit is scored, then the state is GAME_OVER. Game end overrides the COOLDOWN/ACTIVE next-state.
- Countdown priority vs miss: a mole timeout on the final tick counts the miss.
- Start is ignored in SPAWN/ACTIVE/COOLDOWN. Ticks in IDLE and GAME_OVER have no effect.
- Multiple btn bits including the mole's bit count as one hit, not a miss.
- score and misses saturate at 255 and never wrap.

Optional Feature:
- Macro HIT_SPEEDUP_EN.
- Defined: the spawn reload value starts at MOLE_TICKS and decrements by 1 after every 5th hit (score%5==0 after the increment), with a minimum of 1. It is restored to MOLE_TICKS on start.
- Not defined: every spawn loads MOLE_TICKS; no extra registers.

Decomposition:
- Package game_pkg: state enum (IDLE, SPAWN, ACTIVE, COOLDOWN, GAME_OVER), LFSR tap constant, score/misses width constant (8), speedup interval constant (5).
- Sub-module lfsr8: enable, seed parameter, 8-bit state output; instantiated once.

Test Plan:
- Reset with slow_clk toggling -> all outputs 0, state IDLE; no mole appears without start.
- start, then press btn==mole on the cycle after the mole appears -> score=1, mole=0 next cycle; after the next tick a new mole appears at a different hole than before.
- start, no presses for MOLE_TICKS=3 ticks -> misses=1 on the 3rd tick, mole clears, respawn one tick later.
- While the mole is at hole 2, press hole 5 -> misses+1, mole stays at hole 2; press holes 2 and 5 together -> score+1, misses unchanged.
- GAME_TICKS=4, hit coincident with the 4th tick -> score incremented, game_over=1, mole=0, time_left=0; later ticks change nothing; start -> score=0, time_left=4.
- Force score=255 and hit -> score stays 255. With HIT_SPEEDUP_EN, after 5 hits the mole timeout drops from 3 to 2 ticks.
